// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and helpers for the FIFO write-port arbiter and its round-robin
// picker.
//   arb_state_e    : arbiter FSM states (ARB_IDLE, ARB_LOCK)
//   id_w(n)        : index width for n requesters, never less than 1
//   ARB_MAX_N_REQ  : largest supported requester count
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

   localparam int ARB_MAX_N_REQ = 8;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_e;

   function automatic int id_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Returns the first set request bit
// found scanning upward from i_ptr, wrapping modulo N.
//   i_req [N]  : request vector
//   i_ptr [IW] : scan start index (must be < N)
//   o_gnt [N]  : one-hot grant, all zero when nothing is requested
//   o_idx [IW] : index of the granted bit (0 when o_any is low)
//   o_any      : at least one request is set
// -----------------------------------------------------------------------------
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = id_w(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   int            w_pos;
   logic [IW-1:0] w_idx;

   // Scan from the farthest offset down to offset 0 so the candidate closest
   // to i_ptr is the last one written and therefore wins.
   always_comb begin
      // NOTE: every variable gets a value before any branch; a path that left
      // one unassigned would make it hold its old value, i.e. infer a latch.
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      w_pos = 0;
      w_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_pos = int'(i_ptr) + k;
         if (w_pos >= N) begin
            w_pos = w_pos - N;
         end
         w_idx = IW'(w_pos);
         if (i_req[w_idx]) begin
            o_gnt        = '0;
            o_gnt[w_idx] = 1'b1;
            o_idx        = w_idx;
            o_any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing the FIFO write port between N_REQ ready/valid
// producer streams. A winner may keep the grant for up to MAX_BURST beats so
// short packets stay contiguous. Beats pass through one registered output
// stage; there is no combinational path from io_in_* to io_out_*.
//
// Parameters: N_REQ (2..8), DATA_W, MAX_BURST (1..16)
// Ports:
//   io_clk, io_rst_n : clock, asynchronous active-low reset
//   io_in_valid [N]  : per-requester valid
//   io_in_ready [N]  : per-requester ready, at most one bit set
//   io_in_bits       : requester i drives [i*DATA_W +: DATA_W]
//   io_in_last [N]   : final beat of a requester's burst
//   io_out_valid/io_out_ready/io_out_bits : FIFO write handshake
//   io_out_id        : source index of the held beat (FIFO_ARB_ID_EN only)
//
// Build option: define FIFO_ARB_ID_EN to add the io_out_id port and register.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                      io_clk,
   input  logic                      io_rst_n,
   input  logic [N_REQ-1:0]          io_in_valid,
   output logic [N_REQ-1:0]          io_in_ready,
   input  logic [N_REQ*DATA_W-1:0]   io_in_bits,
   input  logic [N_REQ-1:0]          io_in_last,
   output logic                      io_out_valid,
   input  logic                      io_out_ready,
   output logic [DATA_W-1:0]         io_out_bits
`ifdef FIFO_ARB_ID_EN
   ,
   output logic [id_w(N_REQ)-1:0]    io_out_id
`endif
);

   localparam int ID_W  = id_w(N_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   arb_state_e        r_state, w_state_nxt;
   logic [ID_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
   logic [ID_W-1:0]   r_cur, w_cur_nxt;
   logic [CNT_W-1:0]  r_beat_cnt, w_beat_cnt_nxt, w_beat_inc;

   logic [N_REQ-1:0]  w_pick_gnt;
   logic [ID_W-1:0]   w_pick_idx;
   logic              w_pick_any;

   logic [N_REQ-1:0]  w_grant_vec;
   logic [ID_W-1:0]   w_grant_idx;
   logic              w_grant_vld;
   logic              w_load_ok;
   logic              w_accept;
   logic              w_last;

   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_bits;

   function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx);
      return (idx == ID_W'(N_REQ - 1)) ? '0 : idx + ID_W'(1);
   endfunction

   rr_pick #(
      .N  (N_REQ),
      .IW (ID_W)
   ) u_rr_pick (
      .i_req (io_in_valid),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_pick_gnt),
      .o_idx (w_pick_idx),
      .o_any (w_pick_any)
   );

   // The output register can take a new beat when empty or draining this cycle.
   assign w_load_ok = !r_out_valid || io_out_ready;

   // Grant source: the picker while idle, the locked owner during a burst.
   always_comb begin
      w_grant_vec = '0;
      w_grant_idx = r_cur;
      w_grant_vld = 1'b0;
      if (r_state == ARB_IDLE) begin
         w_grant_vec = w_pick_gnt;
         w_grant_idx = w_pick_idx;
         w_grant_vld = w_pick_any;
      end else begin
         w_grant_vld        = io_in_valid[r_cur];
         w_grant_vec[r_cur] = io_in_valid[r_cur];
      end
   end

   assign w_accept   = w_grant_vld && w_load_ok;
   assign w_last     = io_in_last[w_grant_idx];
   assign w_beat_inc = r_beat_cnt + CNT_W'(1);

   // Ready is forced low while reset is asserted, independent of the clock.
   assign io_in_ready = (w_load_ok && io_rst_n) ? w_grant_vec : '0;

   // Next-state logic. A release only moves rr_ptr; the new pick happens in
   // the following IDLE cycle. Everything holds while the FIFO stalls.
   always_comb begin
      w_state_nxt    = r_state;
      w_rr_ptr_nxt   = r_rr_ptr;
      w_cur_nxt      = r_cur;
      w_beat_cnt_nxt = r_beat_cnt;
      case (r_state)
         ARB_IDLE: begin
            if (w_accept) begin
               if (!w_last && (MAX_BURST > 1)) begin
                  w_state_nxt    = ARB_LOCK;
                  w_cur_nxt      = w_grant_idx;
                  w_beat_cnt_nxt = CNT_W'(1);
               end else begin
                  w_rr_ptr_nxt = wrap_inc(w_grant_idx);
               end
            end
         end
         ARB_LOCK: begin
            if (w_load_ok) begin
               if (!io_in_valid[r_cur]) begin
                  // Owner went quiet: the burst is abandoned.
                  w_state_nxt    = ARB_IDLE;
                  w_rr_ptr_nxt   = wrap_inc(r_cur);
                  w_beat_cnt_nxt = '0;
               end else if (w_last || (w_beat_inc == CNT_W'(MAX_BURST))) begin
                  w_state_nxt    = ARB_IDLE;
                  w_rr_ptr_nxt   = wrap_inc(r_cur);
                  w_beat_cnt_nxt = '0;
               end else begin
                  w_beat_cnt_nxt = w_beat_inc;
               end
            end
         end
         default: begin
            w_state_nxt = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge io_clk or negedge io_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, regardless of statement or block order.
      if (!io_rst_n) begin
         r_state    <= ARB_IDLE;
         r_rr_ptr   <= '0;
         r_cur      <= '0;
         r_beat_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
         r_cur      <= w_cur_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
      end
   end

   // Output stage. Bits only change on a load, so they are stable while the
   // FIFO holds off.
   always_ff @(posedge io_clk or negedge io_rst_n) begin
      if (!io_rst_n) begin
         // NOTE: the data register is reset too, because its value is
         // directly visible on io_out_bits and must read 0 after reset.
         r_out_valid <= 1'b0;
         r_out_bits  <= '0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_bits  <= io_in_bits[w_grant_idx*DATA_W +: DATA_W];
      end else if (io_out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign io_out_valid = r_out_valid;
   assign io_out_bits  = r_out_bits;

`ifdef FIFO_ARB_ID_EN
   logic [ID_W-1:0] r_out_id;

   always_ff @(posedge io_clk or negedge io_rst_n) begin
      if (!io_rst_n) begin
         r_out_id <= '0;
      end else if (w_accept) begin
         r_out_id <= w_grant_idx;
      end
   end

   assign io_out_id = r_out_id;
`else
   // Without the id output the grant index only steers the data mux.
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed scenarios followed by random traffic, all checked every cycle
// against a transaction-level reference of the arbitration rules.
// Requester i drives data {i[2:0], seq[4:0]} unless a fixed beat is queued.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 4;

   logic                io_clk = 1'b0;
   logic                io_rst_n = 1'b0;
   logic [N-1:0]        io_in_valid = '0;
   logic [N-1:0]        io_in_ready;
   logic [N*DW-1:0]     io_in_bits = '0;
   logic [N-1:0]        io_in_last = '0;
   logic                io_out_valid;
   logic                io_out_ready = 1'b1;
   logic [DW-1:0]       io_out_bits;
`ifdef FIFO_ARB_ID_EN
   logic [1:0]          io_out_id;
`endif

   fifo_wr_arbiter #(
      .N_REQ     (N),
      .DATA_W    (DW),
      .MAX_BURST (MB)
   ) dut (
      .io_clk       (io_clk),
      .io_rst_n     (io_rst_n),
      .io_in_valid  (io_in_valid),
      .io_in_ready  (io_in_ready),
      .io_in_bits   (io_in_bits),
      .io_in_last   (io_in_last),
      .io_out_valid (io_out_valid),
      .io_out_ready (io_out_ready),
      .io_out_bits  (io_out_bits)
`ifdef FIFO_ARB_ID_EN
      ,
      .io_out_id    (io_out_id)
`endif
   );

   always #5 io_clk = ~io_clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Reference state: who owns the port, how many beats of the burst were
   // taken, where the next idle scan starts, and what sits in the output slot.
   bit            m_locked;
   int            m_owner;
   int            m_beats;
   int            m_rr;
   bit            m_out_valid;
   logic [DW-1:0] m_out_bits;
   int            m_out_id;

   logic [4:0]    seq [N];
   logic [8:0]    fix_q [$];     // {last, data} beats for requester 0
   logic [DW-1:0] log_q [$];     // beats delivered to the FIFO
   int            log_cyc [$];

   int exp_ids3 [7] = '{1, 1, 1, 1, 2, 1, 1};

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_locked    = 1'b0;
      m_owner     = 0;
      m_beats     = 0;
      m_rr        = 0;
      m_out_valid = 1'b0;
      m_out_bits  = '0;
      m_out_id    = 0;
      fix_q.delete();
   endtask

   task automatic do_reset();
      @(negedge io_clk);
      io_in_valid  = '1;
      io_in_last   = '0;
      io_out_ready = 1'b1;
      io_rst_n     = 1'b0;
      #1;
      check("rst_out_valid", 32'(io_out_valid), 0);
      check("rst_in_ready", 32'(io_in_ready), 0);
      check("rst_out_bits", 32'(io_out_bits), 0);
`ifdef FIFO_ARB_ID_EN
      check("rst_out_id", 32'(io_out_id), 0);
`endif
      model_reset();
      @(negedge io_clk);
      io_rst_n    = 1'b1;
      io_in_valid = '0;
   endtask

   // One clock cycle: drive at the falling edge, check 1 time unit later,
   // then advance the reference across the coming rising edge.
   task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] l, input bit ordy);
      logic [N*DW-1:0] bits;
      logic [N-1:0]    last;
      logic [N-1:0]    exp_ready;
      bit              fix_used;
      bit              load_ok;
      bit              gv;
      bit              acc;
      int              g;
      int              idx;
      @(negedge io_clk);
      fix_used = (fix_q.size() > 0);
      for (int i = 0; i < N; i++) begin
         bits[i*DW +: DW] = {3'(i), seq[i]};
         last[i]          = l[i];
      end
      if (fix_used) begin
         bits[DW-1:0] = fix_q[0][7:0];
         last[0]      = fix_q[0][8];
      end
      io_in_valid  = v;
      io_in_last   = last;
      io_in_bits   = bits;
      io_out_ready = ordy;
      #1;
      load_ok = !m_out_valid || ordy;
      gv = 1'b0;
      g  = 0;
      if (m_locked) begin
         g  = m_owner;
         gv = v[g];
      end else begin
         for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (!gv && v[idx]) begin
               g  = idx;
               gv = 1'b1;
            end
         end
      end
      exp_ready = '0;
      if (gv && load_ok) exp_ready[g] = 1'b1;
      check("in_ready", 32'(io_in_ready), 32'(exp_ready));
      check("out_valid", 32'(io_out_valid), 32'(m_out_valid));
      if (m_out_valid) begin
         check("out_bits", 32'(io_out_bits), 32'(m_out_bits));
`ifdef FIFO_ARB_ID_EN
         check("out_id", 32'(io_out_id), 32'(m_out_id));
`endif
      end
      if (io_out_valid && ordy) begin
         log_q.push_back(io_out_bits);
         log_cyc.push_back(cyc);
      end
      acc = gv && load_ok;
      if (acc) begin
         m_out_valid = 1'b1;
         m_out_bits  = bits[g*DW +: DW];
         m_out_id    = g;
      end else if (ordy) begin
         m_out_valid = 1'b0;
      end
      if (m_locked) begin
         if (load_ok) begin
            if (!v[g]) begin
               m_locked = 1'b0;
               m_rr     = (g + 1) % N;
            end else begin
               m_beats++;
               if (last[g] || m_beats == MB) begin
                  m_locked = 1'b0;
                  m_rr     = (g + 1) % N;
               end
            end
         end
      end else if (acc) begin
         if (!last[g] && MB > 1) begin
            m_locked = 1'b1;
            m_owner  = g;
            m_beats  = 1;
         end else begin
            m_rr = (g + 1) % N;
         end
      end
      if (acc) begin
         if (g == 0 && fix_used) void'(fix_q.pop_front());
         else seq[g] = seq[g] + 5'd1;
      end
      cyc++;
   endtask

   task automatic clear_log();
      log_q.delete();
      log_cyc.delete();
   endtask

   initial begin
      int            c0;
      int            cnt [N];
      logic [DW-1:0] held;
      for (int i = 0; i < N; i++) seq[i] = '0;
      model_reset();

      // Single requester, fixed three-beat packet.
      do_reset();
      clear_log();
      fix_q.push_back({1'b0, 8'h11});
      fix_q.push_back({1'b0, 8'h22});
      fix_q.push_back({1'b1, 8'h33});
      c0 = cyc;
      repeat (3) cycle(4'b0001, 4'b0000, 1'b1);
      repeat (2) cycle(4'b0000, 4'b0000, 1'b1);
      check("t1_count", 32'(log_q.size()), 3);
      check("t1_beat0", 32'(log_q[0]), 32'h11);
      check("t1_beat1", 32'(log_q[1]), 32'h22);
      check("t1_beat2", 32'(log_q[2]), 32'h33);
      check("t1_latency", 32'(log_cyc[0]), 32'(c0 + 1));
      check("t1_b2b_1", 32'(log_cyc[1] - log_cyc[0]), 1);
      check("t1_b2b_2", 32'(log_cyc[2] - log_cyc[1]), 1);

      // Fairness with single-beat packets from everyone.
      do_reset();
      clear_log();
      repeat (8) cycle(4'b1111, 4'b1111, 1'b1);
      repeat (2) cycle(4'b0000, 4'b0000, 1'b1);
      check("t2_count", 32'(log_q.size()), 8);
      for (int i = 0; i < 6; i++) check("t2_order", 32'(log_q[i][7:5]), 32'(i % N));
      for (int i = 0; i < N; i++) cnt[i] = 0;
      foreach (log_q[i]) cnt[log_q[i][7:5]]++;
      for (int i = 0; i < N; i++) check("t2_share", 32'(cnt[i]), 2);

      // Burst cap: req1 streams, req2 waits its turn.
      do_reset();
      clear_log();
      repeat (7) cycle(4'b0110, 4'b0100, 1'b1);
      repeat (2) cycle(4'b0000, 4'b0000, 1'b1);
      check("t3_count", 32'(log_q.size()), 7);
      for (int i = 0; i < 7; i++) check("t3_src", 32'(log_q[i][7:5]), 32'(exp_ids3[i]));

      // Backpressure: stall five cycles with the slot full.
      clear_log();
      held = {3'd0, seq[0]};
      cycle(4'b0001, 4'b0001, 1'b1);
      repeat (5) begin
         cycle(4'b1111, 4'b1111, 1'b0);
         check("t4_hold_bits", 32'(io_out_bits), 32'(held));
         check("t4_no_ready", 32'(io_in_ready), 0);
      end
      repeat (3) cycle(4'b1111, 4'b1111, 1'b1);
      repeat (2) cycle(4'b0000, 4'b0000, 1'b1);
      check("t4_count", 32'(log_q.size()), 4);
      for (int i = 0; i < 4; i++) check("t4_src", 32'(log_q[i][7:5]), 32'(i));

      // Abandoned burst: req3 drops valid while locked.
      cycle(4'b1000, 4'b0000, 1'b1);
      cycle(4'b1000, 4'b0000, 1'b1);
      cycle(4'b0011, 4'b0000, 1'b1);
      check("t5_release_ready", 32'(io_in_ready), 0);
      cycle(4'b1011, 4'b1011, 1'b1);
      check("t5_next_grant", 32'(io_in_ready), 32'(4'b0001));
      repeat (2) cycle(4'b0000, 4'b0000, 1'b1);

      // Reset in the middle of a burst.
      cycle(4'b0100, 4'b0000, 1'b1);
      cycle(4'b0100, 4'b0000, 1'b1);
      do_reset();
      cycle(4'b1010, 4'b1010, 1'b1);
      check("t6_first_grant", 32'(io_in_ready), 32'(4'b0010));
      repeat (2) cycle(4'b0000, 4'b0000, 1'b1);

      // Random traffic with random FIFO stalls.
      for (int n = 0; n < 600; n++) begin
         logic [N-1:0] rv;
         logic [N-1:0] rl;
         for (int i = 0; i < N; i++) begin
            rv[i] = ($urandom_range(0, 4) != 0);
            rl[i] = ($urandom_range(0, 3) == 0);
         end
         cycle(rv, rl, ($urandom_range(0, 3) != 0));
      end
      repeat (3) cycle(4'b0000, 4'b0000, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter sharing the single write port of the `fifo` block between `N_REQ` producer streams. It accepts ready/valid beats from each requester and forwards them through one registered output stage onto the FIFO's `io_write_valid`/`io_write_ready`/`io_write_bits` handshake. It sits in the write-clock domain directly upstream of the FIFO. A requester can hold the grant for a burst of up to `MAX_BURST` beats so that short packets stay contiguous.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: beat width; must equal the FIFO data width.
- `MAX_BURST`, 4: maximum consecutive beats per grant, 1..16.
- `io_clk` in 1: single clock, same clock as the FIFO `io_wr_clk`.
- `io_rst_n` in 1: reset, asynchronous assert, active-low.
- `io_in_valid` in `N_REQ`: per-requester valid.
- `io_in_ready` out `N_REQ`: per-requester ready; at most one bit set.
- `io_in_bits` in `N_REQ*DATA_W`: requester `i` drives slice `[i*DATA_W +: DATA_W]`.
- `io_in_last` in `N_REQ`: marks the final beat of a requester's burst.
- `io_out_valid` out 1: to FIFO `io_write_valid`.
- `io_out_ready` in 1: from FIFO `io_write_ready`.
- `io_out_bits` out `DATA_W`: to FIFO `io_write_bits`.
- `io_out_id` out `ID_W`: source index of the beat in the output register. Present only with `FIFO_ARB_ID_EN`.

## Operation
- **Output register:** one entry. It can load when `!io_out_valid || io_out_ready`; call this condition `load_ok`.
- **Ready:** `io_in_ready[g] = (g == grant) && io_in_valid[g] && load_ok`. A beat is accepted when `io_in_valid[g] && io_in_ready[g]`.
- **IDLE state:**
  - `grant` = first valid requester scanning from `rr_ptr` upward, wrapping modulo `N_REQ`.
  - No valid requester: no grant, no accept.
  - On accept with `!last` and `MAX_BURST > 1`: go to LOCK, set `cur = grant`, `beat_cnt = 1`.
  - On accept otherwise: `rr_ptr = grant+1` (mod `N_REQ`), stay in IDLE.
- **LOCK state:**
  - `grant = cur`. Other requesters are ignored.
  - On accept: `beat_cnt++`.
  - Release to IDLE, with `rr_ptr = cur+1`, when the accepted beat has `last` set, or when `beat_cnt+1 == MAX_BURST`.
  - If `io_in_valid[cur]` is low for one cycle: release to IDLE with `rr_ptr = cur+1` and no accept that cycle. The burst is abandoned.
- **Release cycle:** a release and a new IDLE pick never occur in the same cycle. IDLE picks on the cycle after release, so there are no bubbles beyond that.
- **FIFO full:** `io_out_ready` low with `io_out_valid` high holds the output register and forces all `io_in_ready` to 0. State and `beat_cnt` are frozen.
- **Arithmetic:** `beat_cnt` is `$clog2(MAX_BURST+1)` bits and never exceeds `MAX_BURST-1` while in LOCK. `rr_ptr` wraps `N_REQ-1 -> 0`.

## Timing
- **Reset values:**
  - `io_out_valid` = 0, `io_out_bits` = 0, `io_out_id` = 0.
  - `io_in_ready` = 0 (combinational; forced 0 while `io_rst_n` is low).
  - State IDLE, `rr_ptr` = 0, `cur` = 0, `beat_cnt` = 0.
- **Latency:** a beat accepted at edge N appears on `io_out_*` after edge N and is visible in cycle N+1.
- **Throughput:** 1 beat/cycle while the FIFO is ready.
- **Combinational paths:** `io_in_ready` depends combinationally on `io_in_valid` and `io_out_ready`. There is no path from `io_in_*` to `io_out_*`.
- **Reset mid-burst:** async reset clears the output register; any beat held there is dropped. Requesters must restart their packets.
- **Handshake rule:** `io_out_bits` and `io_out_id` are stable while `io_out_valid && !io_out_ready`.

## Configuration
- **`FIFO_ARB_ID_EN` defined:** `io_out_id` port exists and is registered alongside `io_out_bits` with the granted index.
- **`FIFO_ARB_ID_EN` undefined:** the port and its register are absent. All other behaviour is identical.

## Structure
- **Package `fifo_arb_pkg`:**
  - state enum `arb_state_e` {`ARB_IDLE`, `ARB_LOCK`};
  - function `id_w(n)` = `$clog2(n)` (min 1);
  - constant `ARB_MAX_N_REQ` = 8.
- **Sub-module `rr_pick`:** combinational round-robin priority picker. Inputs: request vector, start pointer. Outputs: one-hot grant, index, `any`. Reused by the future read-side scheduler.

## Test plan
1. **Single requester:** reset, req0 sends 3 beats 0x11,0x22,0x33 (`last` on 0x33), FIFO ready -> `io_out_bits` 0x11,0x22,0x33 on consecutive cycles starting 1 cycle after first accept; `io_out_id` = 0.
2. **Fairness:** all 4 requesters hold valid with `last` on every beat -> grant order 0,1,2,3,0,1; each gets exactly 2 of 8 beats.
3. **Burst cap:** `MAX_BURST` = 4, req1 streams 6 beats without `last`, req2 valid -> out ids 1,1,1,1,2,…; req1 regains the grant only after req2 is served.
4. **Backpressure:** `io_out_ready` low for 5 cycles with `io_out_valid` = 1 -> `io_out_bits` constant, all `io_in_ready` = 0. Release -> no beat lost or duplicated.
5. **Abandoned burst:** req3 in LOCK drops valid for 1 cycle -> FSM returns to IDLE, `rr_ptr` = 0, next grant goes to req0 if valid.
6. **Reset mid-burst:** `io_rst_n` low during LOCK -> same cycle `io_out_valid` = 0, `io_in_ready` = 0. After release, first grant goes to lowest valid index from 0.
